mips_inst_encoder: RTL and testbench

// Field-level to 32-bit MIPS instruction encoder; inverse of the SCPU opcode/control decode path.

---
 rtl/mips_inst_encoder.sv | 213 +++++++++++++++++++++
 tb/tb_mips_inst_encoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_inst_encoder.sv
// rtl/mips_inst_encoder.sv - field-level MIPS instruction encoder streaming words into instruction memory
module mips_inst_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [5:0]    req_op,
    input  logic [4:0]    req_rs,
    input  logic [4:0]    req_rt,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_shamt,
    input  logic [15:0]   req_imm,
    input  logic [25:0]   req_target,
    input  logic          req_last,
    output logic          im_we,
    input  logic          im_ready,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          done,
    output logic          err_illegal,
    output logic [15:0]   word_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          enc_valid_q, enc_valid_d;
    logic          enc_last_q, enc_last_d;
    logic          enc_illegal_q, enc_illegal_d;
    logic [31:0]   enc_word_q, enc_word_d;
    logic [32:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wc_q, wc_d;
    logic          err_q, err_d;
    logic          last_acc_q, last_acc_d;
    logic          ill_last_q, ill_last_d;
    logic [PW+1:0] occupancy;
    logic          accept, push, pop, head_last;
    logic [32:0]   enc_result;

    // Returns {legal, word}; forced fields override whatever the requester supplied.
    function automatic logic [32:0] encode(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  sh,
        input logic [15:0] imm,
        input logic [25:0] tgt
    );
        logic [5:0] funct, opc;
        logic [4:0] e_rs, e_rt, e_rd, e_sh;
        logic       legal;
        funct = 6'h00;
        opc   = 6'h00;
        e_rs  = rs;
        e_rt  = rt;
        e_rd  = rd;
        e_sh  = 5'd0;
        legal = 1'b1;
        case (op)
            6'd0:  funct = 6'h20;
            6'd1:  funct = 6'h21;
            6'd2:  funct = 6'h22;
            6'd3:  funct = 6'h24;
            6'd4:  funct = 6'h25;
            6'd5:  funct = 6'h26;
            6'd6:  funct = 6'h2A;
            6'd7:  funct = 6'h2B;
            6'd8:  begin funct = 6'h00; e_rs = 5'd0; e_sh = sh; end
            6'd9:  begin funct = 6'h02; e_rs = 5'd0; e_sh = sh; end
            6'd10: begin funct = 6'h03; e_rs = 5'd0; e_sh = sh; end
            6'd11: begin funct = 6'h08; e_rt = 5'd0; e_rd = 5'd0; end
            6'd12: opc = 6'h08;
            6'd13: opc = 6'h09;
            6'd14: opc = 6'h0C;
            6'd15: opc = 6'h0D;
            6'd16: opc = 6'h0E;
            6'd17: begin opc = 6'h0F; e_rs = 5'd0; end
            6'd18: opc = 6'h0A;
            6'd19: opc = 6'h0B;
            6'd20: opc = 6'h23;
            6'd21: opc = 6'h20;
            6'd22: opc = 6'h24;
            6'd23: opc = 6'h21;
            6'd24: opc = 6'h25;
            6'd25: opc = 6'h2B;
            6'd26: opc = 6'h04;
            6'd27: opc = 6'h05;
            6'd28: begin opc = 6'h01; e_rt = 5'd1; end
            6'd29: begin opc = 6'h01; e_rt = 5'd0; end
            6'd30: begin opc = 6'h07; e_rt = 5'd0; end
            6'd31: begin opc = 6'h06; e_rt = 5'd0; end
            6'd32: opc = 6'h02;
            6'd33: opc = 6'h03;
            default: legal = 1'b0;
        endcase
        if (op <= 6'd11) return {legal, 6'h00, e_rs, e_rt, e_rd, e_sh, funct};
        if (op <= 6'd31) return {legal, opc, e_rs, e_rt, imm};
        if (op <= 6'd33) return {legal, opc, tgt};
        return {legal, 32'h0};
    endfunction

    assign enc_result = encode(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target);
    assign occupancy  = {1'b0, count_q} + {{(PW+1){1'b0}}, enc_valid_q};
    assign req_ready  = (state_q == S_STREAM) && !last_acc_q && (occupancy < (PW+2)'(DEPTH));
    assign im_we      = (count_q != '0);
    assign im_wdata   = im_we ? mem_q[rd_ptr_q][31:0] : 32'h0;
    assign head_last  = mem_q[rd_ptr_q][32];
    assign im_addr    = addr_q;
    assign done       = (state_q == S_DONE);
    assign err_illegal = err_q;
    assign word_count = wc_q;
    assign accept     = req_valid && req_ready;
    assign push       = enc_valid_q && !enc_illegal_q;
    assign pop        = im_we && im_ready;

    always_comb begin
        state_d       = state_q;
        enc_valid_d   = enc_valid_q;
        enc_last_d    = enc_last_q;
        enc_illegal_d = enc_illegal_q;
        enc_word_d    = enc_word_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        addr_d        = addr_q;
        wc_d          = wc_q;
        err_d         = err_q;
        last_acc_d    = last_acc_q;
        ill_last_d    = ill_last_q;
        if (start) begin
            // start wins over everything in flight, including a same-cycle accept or write
            state_d     = S_STREAM;
            enc_valid_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            addr_d      = base_addr & {{(AW-2){1'b1}}, 2'b00};
            wc_d        = 16'h0;
            err_d       = 1'b0;
            last_acc_d  = 1'b0;
            ill_last_d  = 1'b0;
        end else begin
            enc_valid_d = accept;
            if (accept) begin
                enc_word_d    = enc_result[31:0];
                enc_last_d    = req_last;
                enc_illegal_d = !enc_result[32];
                if (!enc_result[32]) err_d = 1'b1;
                if (req_last) last_acc_d = 1'b1;
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                addr_d   = addr_q + {{(AW-3){1'b0}}, 3'b100};
                if (wc_q != 16'hFFFF) wc_d = wc_q + 16'h1;
            end
            count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (enc_valid_q && enc_illegal_q && enc_last_q) ill_last_d = 1'b1;
            if (state_q == S_STREAM && ((pop && head_last) || (ill_last_q && count_q == '0)))
                state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            enc_valid_q   <= 1'b0;
            enc_last_q    <= 1'b0;
            enc_illegal_q <= 1'b0;
            enc_word_q    <= 32'h0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            addr_q        <= '0;
            wc_q          <= 16'h0;
            err_q         <= 1'b0;
            last_acc_q    <= 1'b0;
            ill_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            enc_valid_q   <= enc_valid_d;
            enc_last_q    <= enc_last_d;
            enc_illegal_q <= enc_illegal_d;
            enc_word_q    <= enc_word_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            addr_q        <= addr_d;
            wc_q          <= wc_d;
            err_q         <= err_d;
            last_acc_q    <= last_acc_d;
            ill_last_q    <= ill_last_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 33'h0;
        end else if (push && !start) begin
            mem_q[wr_ptr_q] <= {enc_last_q, enc_word_q};
        end
    end
endmodule

// File: tb/tb_mips_inst_encoder.sv
// tb/tb_mips_inst_encoder.sv - scoreboard bench for mips_inst_encoder
module tb_mips_inst_encoder;
    logic        clk = 1'b0;
    logic        rstn, start, req_valid, req_ready, req_last;
    logic [31:0] base_addr, im_addr, im_wdata;
    logic [5:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [15:0] req_imm, word_count;
    logic [25:0] req_target;
    logic        im_we, im_ready, done, err_illegal;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_d[$];
    logic [31:0] exp_a[$];
    logic [31:0] next_addr;
    int          model_cnt;
    bit          rand_ready = 0;

    mips_inst_encoder #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
        .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
        .done(done), .err_illegal(err_illegal), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Reference encoding built from opcode/funct tables
    function automatic logic [31:0] model(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [15:0] imm, input logic [25:0] tgt);
        logic [5:0] rfun [12];
        logic [5:0] iopc [20];
        rfun = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
        iopc = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h0B, 6'h23, 6'h20,
                 6'h24, 6'h21, 6'h25, 6'h2B, 6'h04, 6'h05, 6'h01, 6'h01, 6'h07, 6'h06};
        if (op < 8)  return {6'd0, rs, rt, rd, 5'd0, rfun[op]};
        if (op < 11) return {6'd0, 5'd0, rt, rd, sh, rfun[op]};
        if (op == 11) return {6'd0, rs, 15'd0, 6'h08};
        if (op == 17) return {6'h0F, 5'd0, rt, imm};
        if (op == 28) return {6'h01, rs, 5'd1, imm};
        if (op >= 29 && op <= 31) return {iopc[op-12], rs, 5'd0, imm};
        if (op < 32) return {iopc[op-12], rs, rt, imm};
        return {(op == 32) ? 6'h02 : 6'h03, tgt};
    endfunction

    task automatic tick();
        logic [31:0] d, a;
        if (rstn && !start && im_we && im_ready) begin
            checks++;
            if (exp_d.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", im_addr, im_wdata);
            end else begin
                d = exp_d.pop_front();
                a = exp_a.pop_front();
                if (im_wdata !== d || im_addr !== a) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h", im_addr, im_wdata, a, d);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (rand_ready) im_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_exp(input logic [31:0] w);
        exp_d.push_back(w);
        exp_a.push_back(next_addr);
        next_addr = next_addr + 32'd4;
        model_cnt++;
    endtask

    task automatic do_start(input logic [31:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
        exp_d.delete();
        exp_a.delete();
        next_addr = b & 32'hFFFF_FFFC;
        model_cnt = 0;
    endtask

    task automatic set_fields(input int op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt, input logic last);
        req_op = 6'(op); req_rs = rs; req_rt = rt; req_rd = rd;
        req_shamt = sh; req_imm = imm; req_target = tgt; req_last = last;
    endtask

    task automatic send(input int op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last, input logic [31:0] exp_w, input logic legal);
        bit acc = 0;
        set_fields(op, rs, rt, rd, sh, imm, tgt, last);
        req_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (req_ready) begin
                acc = 1;
                if (legal) push_exp(exp_w);
            end
            tick();
        end
        req_valid = 1'b0;
        req_last = 1'b0;
        checks++;
        if (!acc) begin errors++; $display("FAIL send_timeout op=%0d got not accepted expected accepted", op); end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_d.size() == 0 && !im_we) break;
            tick();
        end
        checks++;
        if (exp_d.size() != 0 || im_we) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d im_we=%b expected 0 pending", exp_d.size(), im_we);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && !done; i++) tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done_timeout got %b expected 1", done); end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; base_addr = 32'h0; req_valid = 1'b0; im_ready = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        next_addr = 0; model_cnt = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        tick();
        checks += 7;
        if (im_we !== 1'b0)         begin errors++; $display("FAIL rst_im_we got %b expected 0", im_we); end
        if (im_addr !== 32'h0)      begin errors++; $display("FAIL rst_im_addr got %h expected 0", im_addr); end
        if (im_wdata !== 32'h0)     begin errors++; $display("FAIL rst_im_wdata got %h expected 0", im_wdata); end
        if (req_ready !== 1'b0)     begin errors++; $display("FAIL rst_req_ready got %b expected 0", req_ready); end
        if (done !== 1'b0)          begin errors++; $display("FAIL rst_done got %b expected 0", done); end
        if (err_illegal !== 1'b0)   begin errors++; $display("FAIL rst_err got %b expected 0", err_illegal); end
        if (word_count !== 16'h0)   begin errors++; $display("FAIL rst_word_count got %h expected 0", word_count); end
    endtask

    task automatic test_spec_vectors();
        im_ready = 1'b1;
        do_start(32'h100);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL start_ready got %b expected 1", req_ready); end
        send(12, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0, 32'h20080005, 1'b1);
        wait_drain();
        checks += 2;
        if (word_count !== 16'd1)  begin errors++; $display("FAIL addi_count got %0d expected 1", word_count); end
        if (im_addr !== 32'h104)   begin errors++; $display("FAIL addi_addr got %h expected 104", im_addr); end
        send(0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0, 1'b0, 32'h00221820, 1'b1);
        send(8, 5'd9, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0, 32'h00011100, 1'b1);
        send(28, 5'd4, 5'd0, 5'd0, 5'd0, 16'hFFFC, 26'h0, 1'b0, 32'h0481FFFC, 1'b1);
        send(33, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040, 1'b0, 32'h0C000040, 1'b1);
        send(17, 5'd5, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0, 32'h3C011234, 1'b1);
        wait_drain();
        checks++;
        if (word_count !== 16'd6) begin errors++; $display("FAIL vec_count got %0d expected 6", word_count); end
    endtask

    task automatic test_sweep();
        logic [4:0] rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        do_start(32'h1000);
        rand_ready = 1;
        for (int op = 0; op < 34; op++) begin
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
            imm = 16'($urandom); tgt = 26'($urandom);
            send(op, rs, rt, rd, sh, imm, tgt, op == 33, model(op, rs, rt, rd, sh, imm, tgt), 1'b1);
        end
        wait_done();
        rand_ready = 0;
        im_ready = 1'b1;
        checks += 2;
        if (word_count !== 16'd34) begin errors++; $display("FAIL sweep_count got %0d expected 34", word_count); end
        if (exp_d.size() != 0)     begin errors++; $display("FAIL sweep_pending got %0d expected 0", exp_d.size()); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        logic [31:0] hold_w;
        do_start(32'h200);
        im_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) begin
                set_fields(13, 5'd2, 5'(idx), 5'd0, 5'd0, 16'(idx * 3), 26'h0, 1'b0);
                req_valid = 1'b1;
            end else req_valid = 1'b0;
            if (req_valid && req_ready) begin
                push_exp(model(13, 5'd2, 5'(idx), 5'd0, 5'd0, 16'(idx * 3), 26'h0));
                idx++;
            end
            tick();
            hold_w = exp_d[0];
            if (c >= 2) begin
                checks++;
                if (im_we !== 1'b1 || im_wdata !== hold_w || im_addr !== 32'h200) begin
                    errors++;
                    $display("FAIL hold_stable got we=%b data=%h addr=%h expected 1 %h 200", im_we, im_wdata, im_addr, hold_w);
                end
            end
        end
        req_valid = 1'b0;
        checks += 2;
        if (idx != 4)           begin errors++; $display("FAIL bp_accepted got %0d expected 4", idx); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b expected 0", req_ready); end
        im_ready = 1'b1;
        wait_drain();
        send(13, 5'd2, 5'd4, 5'd0, 5'd0, 16'd12, 26'h0, 1'b0, model(13, 5'd2, 5'd4, 5'd0, 5'd0, 16'd12, 26'h0), 1'b1);
        send(13, 5'd2, 5'd5, 5'd0, 5'd0, 16'd15, 26'h0, 1'b0, model(13, 5'd2, 5'd5, 5'd0, 5'd0, 16'd15, 26'h0), 1'b1);
        wait_drain();
        checks++;
        if (word_count !== 16'd6) begin errors++; $display("FAIL bp_count got %0d expected 6", word_count); end
    endtask

    task automatic test_illegal();
        do_start(32'h300);
        send(12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h7, 26'h0, 1'b0, 32'h20220007, 1'b1);
        send(40, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_err got %b expected 1", err_illegal); end
        send(15, 5'd3, 5'd4, 5'd0, 5'd0, 16'hABCD, 26'h0, 1'b1, 32'h3464ABCD, 1'b1);
        wait_done();
        wait_drain();
        checks += 3;
        if (req_ready !== 1'b0)   begin errors++; $display("FAIL illegal_ready got %b expected 0", req_ready); end
        if (word_count !== 16'd2) begin errors++; $display("FAIL illegal_count got %0d expected 2", word_count); end
        if (im_addr !== 32'h308)  begin errors++; $display("FAIL illegal_addr got %h expected 308", im_addr); end
        do_start(32'h700);
        checks++;
        if (err_illegal !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL restart_clear got err=%b done=%b expected 0 0", err_illegal, done);
        end
        send(13, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1, 26'h0, 1'b0, 32'h24010001, 1'b1);
        send(50, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0, 1'b0);
        wait_done();
        checks++;
        if (word_count !== 16'd1) begin errors++; $display("FAIL illegal_last_count got %0d expected 1", word_count); end
    endtask

    task automatic test_wrap_and_abort();
        do_start(32'hFFFF_FFFE);
        send(32, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1'b0, 32'h0BFFFFFF, 1'b1);
        send(11, 5'd31, 5'd7, 5'd7, 5'd7, 16'h0, 26'h0, 1'b0, 32'h03E00008, 1'b1);
        wait_drain();
        checks++;
        if (im_addr !== 32'h4) begin errors++; $display("FAIL wrap_addr got %h expected 4", im_addr); end
        do_start(32'h400);
        im_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(14, 5'(i), 5'(i), 5'd0, 5'd0, 16'(i), 26'h0, 1'b0, model(14, 5'(i), 5'(i), 5'd0, 5'd0, 16'(i), 26'h0), 1'b1);
        tick();
        do_start(32'h500);
        im_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (im_we !== 1'b0) begin errors++; $display("FAIL abort_flush got im_we=%b expected 0", im_we); end
            tick();
        end
        send(16, 5'd1, 5'd1, 5'd0, 5'd0, 16'h5, 26'h0, 1'b0, 32'h38210005, 1'b1);
        wait_drain();
        checks++;
        if (word_count !== 16'd1) begin errors++; $display("FAIL abort_count got %0d expected 1", word_count); end
    endtask

    task automatic test_async_reset();
        do_start(32'h600);
        im_ready = 1'b0;
        send(13, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1, 26'h0, 1'b0, 32'h24010001, 1'b1);
        send(13, 5'd0, 5'd2, 5'd0, 5'd0, 16'h2, 26'h0, 1'b0, 32'h24020002, 1'b1);
        tick();
        #2 rstn = 1'b0;
        #1;
        checks += 3;
        if (im_we !== 1'b0)       begin errors++; $display("FAIL arst_we got %b expected 0", im_we); end
        if (req_ready !== 1'b0)   begin errors++; $display("FAIL arst_ready got %b expected 0", req_ready); end
        if (im_addr !== 32'h0)    begin errors++; $display("FAIL arst_addr got %h expected 0", im_addr); end
        @(negedge clk);
        rstn = 1'b1;
        exp_d.delete();
        exp_a.delete();
        im_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (im_we !== 1'b0 || word_count !== 16'h0) begin
            errors++; $display("FAIL arst_after got we=%b count=%0d expected 0 0", im_we, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_sweep();
        test_backpressure();
        test_illegal();
        test_wrap_and_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
